// File: rtl/rtl_bias_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rtl_bias_sequencer_if
// Brief    : Bundles the load, operand, PE, result and status signals of rtl_bias_sequencer.
//            Optional BIAS_READBACK_EN adds rd_addr/rd_data.
// Revision : 1.0 - initial release
// ============================================================================
interface rtl_bias_sequencer_if #(
    parameter int DATA_W  = 16,
    parameter int NEURONS = 8,
    parameter int IDX_W   = $clog2(NEURONS)
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              start;
    logic              start_training;
    logic [DATA_W-1:0] start_eta;
    logic              in_valid;
    logic [DATA_W-1:0] in_sum;
    logic [DATA_W-1:0] in_delta;
    logic              in_ready;
    logic              pe_ce;
    logic [DATA_W-1:0] pe_sum_in;
    logic [DATA_W-1:0] pe_delta_k;
    logic [DATA_W-1:0] pe_init_bias;
    logic [DATA_W-1:0] pe_eta;
    logic [DATA_W-1:0] pe_training;
    logic [DATA_W-1:0] pe_net_sum;
    logic [DATA_W-1:0] pe_bias_change;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_ready;
    logic              busy;
    logic              done;
`ifdef BIAS_READBACK_EN
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport slave (
        input  ld_valid, ld_data, start, start_training, start_eta,
               in_valid, in_sum, in_delta, pe_net_sum, pe_bias_change,
               out_ready, rd_addr,
        output ld_ready, in_ready, pe_ce, pe_sum_in, pe_delta_k, pe_init_bias,
               pe_eta, pe_training, out_valid, out_data, out_idx, busy, done,
               rd_data
    );
    modport master (
        output ld_valid, ld_data, start, start_training, start_eta,
               in_valid, in_sum, in_delta, pe_net_sum, pe_bias_change,
               out_ready, rd_addr,
        input  ld_ready, in_ready, pe_ce, pe_sum_in, pe_delta_k, pe_init_bias,
               pe_eta, pe_training, out_valid, out_data, out_idx, busy, done,
               rd_data
    );
`else
    modport slave (
        input  ld_valid, ld_data, start, start_training, start_eta,
               in_valid, in_sum, in_delta, pe_net_sum, pe_bias_change,
               out_ready,
        output ld_ready, in_ready, pe_ce, pe_sum_in, pe_delta_k, pe_init_bias,
               pe_eta, pe_training, out_valid, out_data, out_idx, busy, done
    );
    modport master (
        output ld_valid, ld_data, start, start_training, start_eta,
               in_valid, in_sum, in_delta, pe_net_sum, pe_bias_change,
               out_ready,
        input  ld_ready, in_ready, pe_ce, pe_sum_in, pe_delta_k, pe_init_bias,
               pe_eta, pe_training, out_valid, out_data, out_idx, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rtl_bias_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rtl_bias_sequencer
// Brief    : Bias memory, operand driver and result collector for rtl_bias_pe.
//            Optional BIAS_READBACK_EN adds a registered bias readback port.
// Revision : 1.0 - initial release
// ============================================================================
module rtl_bias_sequencer #(
    parameter int DATA_W  = 16,
    parameter int NEURONS = 8,
    parameter int IDX_W   = $clog2(NEURONS)
) (
    input  wire logic           ap_clk,
    input  wire logic           ap_rst,
    rtl_bias_sequencer_if.slave bus
);
    localparam logic [IDX_W-1:0] c_last  = IDX_W'(NEURONS - 1);
    localparam logic [IDX_W:0]   c_count = (IDX_W + 1)'(NEURONS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [NEURONS];
    logic [IDX_W-1:0]  r_ld_ptr;
    logic [IDX_W-1:0]  r_res_ptr;
    logic [IDX_W:0]    r_iss_ptr;
    logic              r_pending;
    logic              r_training;
    logic [DATA_W-1:0] r_eta;
    logic              r_ld_ready;
    logic              r_busy;
    logic              r_done;

    logic w_in_ready;
    logic w_pe_ce;
    logic w_xfer;
    logic w_ld_wr;
    logic w_wb_wr;

    // A new operand may enter while the previous result is leaving this cycle.
    assign w_in_ready = (r_state == S_RUN) && (r_iss_ptr < c_count)
                        && (!r_pending || bus.out_ready);
    assign w_pe_ce    = bus.in_valid && w_in_ready;
    assign w_xfer     = (r_state == S_RUN) && r_pending && bus.out_ready;
    assign w_ld_wr    = bus.ld_valid && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_wb_wr    = w_xfer && r_training;

    assign bus.ld_ready     = r_ld_ready;
    assign bus.in_ready     = w_in_ready;
    assign bus.pe_ce        = w_pe_ce;
    assign bus.pe_sum_in    = bus.in_sum;
    assign bus.pe_delta_k   = bus.in_delta;
    assign bus.pe_init_bias = r_mem[r_iss_ptr[IDX_W-1:0]];
    assign bus.pe_eta       = r_eta;
    assign bus.pe_training  = {{(DATA_W-1){1'b0}}, r_training};
    assign bus.out_valid    = r_pending;
    assign bus.out_data     = bus.pe_net_sum;
    assign bus.out_idx      = r_res_ptr;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

    // Bias storage is deliberately not reset so trained values survive ap_rst.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst) begin
            if (w_ld_wr) begin
                r_mem[r_ld_ptr] <= bus.ld_data;
            end else if (w_wb_wr) begin
                r_mem[r_res_ptr] <= bus.pe_bias_change;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= S_IDLE;
            r_ld_ptr   <= '0;
            r_res_ptr  <= '0;
            r_iss_ptr  <= '0;
            r_pending  <= 1'b0;
            r_training <= 1'b0;
            r_eta      <= '0;
            r_ld_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ld_valid) begin
                        r_state  <= S_LOAD;
                        r_ld_ptr <= IDX_W'(1);
                        r_busy   <= 1'b1;
                    end else if (bus.start) begin
                        r_state    <= S_RUN;
                        r_eta      <= bus.start_eta;
                        r_training <= bus.start_training;
                        r_iss_ptr  <= '0;
                        r_res_ptr  <= '0;
                        r_ld_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        if (r_ld_ptr == c_last) begin
                            r_state  <= S_IDLE;
                            r_ld_ptr <= '0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_ld_ptr <= r_ld_ptr + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_pe_ce) begin
                        r_iss_ptr <= r_iss_ptr + 1'b1;
                    end
                    if (w_xfer) begin
                        r_pending <= w_pe_ce;
                        if (r_res_ptr == c_last) begin
                            r_state   <= S_DONE;
                            r_res_ptr <= '0;
                            r_iss_ptr <= '0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_res_ptr <= r_res_ptr + 1'b1;
                        end
                    end else if (w_pe_ce) begin
                        r_pending <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                    r_ld_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BIAS_READBACK_EN
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[bus.rd_addr];
        end
    end

    assign bus.rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire
